alineador_pipeline: RTL and testbench



---
 rtl/alineador_pipeline.sv | 121 ++++++++++++
 tb/tb_alineador_pipeline.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alineador_pipeline.sv
// Two-stage exponent alignment pipeline for FP add/sub.
// Stage 1 compares exponents, stage 2 shifts with guard/round/sticky.
module alineador_pipeline #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24,
  parameter int BIAS  = 127
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAN_W-1:0] Mantissa_A,
  input  logic [MAN_W-1:0] Mantissa_B,
  input  logic [EXP_W-1:0] Exponente_A,
  input  logic [EXP_W-1:0] Exponente_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W+2:0] Resul_Mantissa_A,
  output logic [MAN_W+2:0] Resul_Mantissa_B,
  output logic [EXP_W-1:0] Exp_comun,
  output logic             swap,
  output logic             sat
);

  localparam int RW = MAN_W + 3;

  typedef struct packed {
    logic             valid;
    logic             swap;
    logic [EXP_W-1:0] diff;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man_l;
    logic [MAN_W-1:0] man_s;
  } s1_t;

  s1_t s1_q;
  s1_t s1_d;

  logic          adv;
  logic [RW-1:0] ext_l;
  logic [RW-1:0] ext_s;
  logic [RW-1:0] sh;
  logic [RW-1:0] back;
  logic [RW-1:0] sm_out;
  logic [31:0]   diff32;
  logic          lost;
  logic          sat_c;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1 next value: order operands by exponent
  always_comb begin
    s1_d       = '0;
    s1_d.valid = in_valid;
    s1_d.swap  = Exponente_B > Exponente_A;
    if (s1_d.swap) begin
      s1_d.diff  = Exponente_B - Exponente_A;
      s1_d.exp   = Exponente_B;
      s1_d.man_l = Mantissa_B;
      s1_d.man_s = Mantissa_A;
    end else begin
      s1_d.diff  = Exponente_A - Exponente_B;
      s1_d.exp   = Exponente_A;
      s1_d.man_l = Mantissa_A;
      s1_d.man_s = Mantissa_B;
    end
  end

  // Stage 1 register, frozen while output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else if (adv) begin
      s1_q.valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // Stage 2 shifter: shifted-out bits collapse into the sticky LSB
  always_comb begin
    ext_l  = {s1_q.man_l, 3'b000};
    ext_s  = {s1_q.man_s, 3'b000};
    diff32 = 32'(s1_q.diff);
    sat_c  = diff32 >= 32'(RW);
    sh     = ext_s >> s1_q.diff;
    back   = sh << s1_q.diff;
    lost   = back != ext_s;
    if (sat_c) sm_out = {{(RW-1){1'b0}}, |s1_q.man_s};
    else       sm_out = {sh[RW-1:1], sh[0] | lost};
  end

  // Output register, routes operands back to A/B slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid        <= 1'b0;
      Resul_Mantissa_A <= '0;
      Resul_Mantissa_B <= '0;
      Exp_comun        <= '0;
      swap             <= 1'b0;
      sat              <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_q.valid;
      if (s1_q.valid) begin
        Resul_Mantissa_A <= s1_q.swap ? sm_out : ext_l;
        Resul_Mantissa_B <= s1_q.swap ? ext_l : sm_out;
        Exp_comun        <= s1_q.exp;
        swap             <= s1_q.swap;
        sat              <= sat_c;
      end
    end
  end

  a_bias: assert property (@(posedge clk) disable iff (!rst_n)
    BIAS < (1 << EXP_W));

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid && !out_ready |=> out_valid
      && $stable(Resul_Mantissa_A) && $stable(Resul_Mantissa_B));

endmodule

// File: tb/tb_alineador_pipeline.sv
// Self-checking bench for alineador_pipeline.
// Random and directed traffic against a queue-based reference model.
module tb_alineador_pipeline;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] Mantissa_A, Mantissa_B;
  logic [7:0]  Exponente_A, Exponente_B;
  logic        out_valid;
  logic        out_ready;
  logic [26:0] Resul_Mantissa_A, Resul_Mantissa_B;
  logic [7:0]  Exp_comun;
  logic        swap, sat;

  alineador_pipeline dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .Mantissa_A(Mantissa_A), .Mantissa_B(Mantissa_B),
    .Exponente_A(Exponente_A), .Exponente_B(Exponente_B),
    .out_valid(out_valid), .out_ready(out_ready),
    .Resul_Mantissa_A(Resul_Mantissa_A),
    .Resul_Mantissa_B(Resul_Mantissa_B),
    .Exp_comun(Exp_comun), .swap(swap), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [26:0] ra;
    logic [26:0] rb;
    logic [7:0]  e;
    logic        sw;
    logic        st;
  } res_t;

  res_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_out = 0;
  bit   stalled = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  function automatic res_t model(input int ma, input int ea,
                                 input int mb, input int eb);
    res_t   r;
    longint big, sml, v, d;
    r.sw = eb > ea;
    d    = r.sw ? eb - ea : ea - eb;
    big  = longint'(r.sw ? mb : ma) * 8;
    sml  = longint'(r.sw ? ma : mb) * 8;
    r.st = d >= 27;
    if (r.st) begin
      v = (sml != 0) ? 1 : 0;
    end else begin
      v = sml / (longint'(1) << d);
      if (sml % (longint'(1) << d) != 0) v = v | 1;
    end
    r.ra = r.sw ? 27'(v) : 27'(big);
    r.rb = r.sw ? 27'(big) : 27'(v);
    r.e  = 8'(r.sw ? eb : ea);
    return r;
  endfunction

  task automatic tick(output bit acc);
    res_t e;
    @(negedge clk);
    chk("in_ready", in_ready, !out_valid || out_ready);
    if (stalled) chk("hold_valid", out_valid, 1);
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious", out_valid, 0);
      end else begin
        e = q[0];
        chk("res_a", Resul_Mantissa_A, e.ra);
        chk("res_b", Resul_Mantissa_B, e.rb);
        chk("exp", Exp_comun, e.e);
        chk("swap", swap, e.sw);
        chk("sat", sat, e.st);
        if (out_ready) begin
          void'(q.pop_front());
          n_out++;
        end
      end
    end
    stalled = out_valid && !out_ready;
    acc = in_valid && in_ready;
    if (acc)
      q.push_back(model(int'(Mantissa_A), int'(Exponente_A),
                        int'(Mantissa_B), int'(Exponente_B)));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [23:0] ma, input logic [7:0] ea,
                       input logic [23:0] mb, input logic [7:0] eb);
    Mantissa_A  = ma;
    Exponente_A = ea;
    Mantissa_B  = mb;
    Exponente_B = eb;
  endtask

  task automatic directed(input logic [23:0] ma, input logic [7:0] ea,
                          input logic [23:0] mb, input logic [7:0] eb,
                          input logic [26:0] xa, input logic [26:0] xb,
                          input logic [7:0] xe, input logic xs,
                          input logic xt);
    bit acc;
    out_ready = 1'b1;
    drive(ma, ea, mb, eb);
    in_valid = 1'b1;
    tick(acc);
    in_valid = 1'b0;
    tick(acc);
    chk("dir_lat", out_valid, 1);
    chk("dir_a", Resul_Mantissa_A, xa);
    chk("dir_b", Resul_Mantissa_B, xb);
    chk("dir_exp", Exp_comun, xe);
    chk("dir_swap", swap, xs);
    chk("dir_sat", sat, xt);
    tick(acc);
  endtask

  task automatic rand_pair();
    int ea, m;
    ea = int'($urandom_range(0, 255));
    Exponente_A = 8'(ea);
    if ($urandom_range(0, 1) == 1) Exponente_B = 8'($urandom);
    else Exponente_B = 8'(ea) ^ 8'($urandom_range(0, 31));
    m = int'($urandom_range(0, 3));
    Mantissa_A = (m == 0) ? 24'h0 : {1'b1, 23'($urandom)};
    Mantissa_B = (m == 1) ? 24'($urandom) : {1'b1, 23'($urandom)};
  endtask

  initial begin
    bit acc;
    int n0, k, st, c;
    logic [23:0] sa [3];
    logic [7:0]  se [3];

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive(24'h0, 8'h0, 24'h0, 8'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_a", Resul_Mantissa_A, 0);
    chk("rst_swap", swap, 0);
    chk("rst_sat", sat, 0);
    rst_n = 1'b1;

    directed(24'hC00000, 130, 24'h800000, 128,
             27'h6000000, 27'h1000000, 130, 0, 0);
    directed(24'h800000, 100, 24'h800001, 104,
             27'h0400000, 27'h4000008, 104, 1, 0);
    directed(24'h800001, 100, 24'h800000, 104,
             27'h0400001, 27'h4000000, 104, 1, 0);
    directed(24'h800000, 200, 24'h800000, 160,
             27'h4000000, 27'h0000001, 200, 0, 1);
    directed(24'h800000, 200, 24'h000000, 160,
             27'h4000000, 27'h0000000, 200, 0, 1);
    directed(24'h123456, 50, 24'hABCDEF, 50,
             27'h091A2B0, 27'h55E6F78, 50, 0, 0);
    directed(24'h000001, 0, 24'hFFFFFF, 26,
             27'h0000001, 27'h7FFFFF8, 26, 1, 0);
    directed(24'h800000, 27, 24'h400000, 0,
             27'h4000000, 27'h0000001, 27, 0, 1);

    sa = '{24'hC00000, 24'h812345, 24'hFFFFFF};
    se = '{8'd10, 8'd40, 8'd90};
    n0 = n_out;
    k = 0;
    st = -1;
    c = 0;
    while (n_out < n0 + 3 && c < 40) begin
      in_valid = k < 3;
      if (k < 3) drive(sa[k], se[k], 24'h800000 | 24'(k), se[k] - 8'd3);
      if (st < 0 && out_valid) st = 4;
      out_ready = !(st > 0);
      #1;
      if (st > 0) begin
        chk("stall_ready", in_ready, 0);
        chk("stall_valid", out_valid, 1);
        st--;
      end
      tick(acc);
      if (acc) k++;
      c++;
    end
    in_valid = 1'b0;
    chk("stream_count", n_out - n0, 3);
    chk("stream_sent", k, 3);

    for (int i = 0; i < 600; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      rand_pair();
      tick(acc);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick(acc);
    chk("drain", q.size(), 0);

    out_ready = 1'b1;
    rand_pair();
    in_valid = 1'b1;
    tick(acc);
    rand_pair();
    tick(acc);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    q.delete();
    stalled = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = n_out;
    tick(acc);
    chk("post_rst_idle", out_valid, 0);
    drive(24'hC00000, 130, 24'h800000, 128);
    in_valid = 1'b1;
    tick(acc);
    in_valid = 1'b0;
    tick(acc);
    chk("post_rst_lat", out_valid, 1);
    chk("post_rst_a", Resul_Mantissa_A, 27'h6000000);
    repeat (4) tick(acc);
    chk("post_rst_count", n_out - n0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
